// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and width constants for the MEM stage controller.
package mem_pkg;
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
   localparam int TIMEOUT_DEF = 16;
   localparam int REG_W = 5;
   localparam int DATA_W = 32;
endpackage

// File: rtl/mem_wdog.sv
// mem_wdog: counts WAIT cycles; expired is high during the last allowed WAIT cycle.
module mem_wdog
   import mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = clear ? '0 : start ? cnt_q + 1'b1 : cnt_q;
   end
   assign expired = start && (cnt_q == CW'(TIMEOUT - 1));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage issuing one data-memory request at a time,
// stalling upstream while it waits, with a watchdog that abandons silent requests.
module mem_stage_ctrl
   import mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int AW      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] inAdder,
   input  logic              inZf,
   input  logic [DATA_W-1:0] inOutAlu,
   input  logic [DATA_W-1:0] inRD2,
   input  logic [REG_W-1:0]  inMux5b,
   input  logic              inValid,
   input  logic              inMemRead,
   input  logic              inMemWrite,
   input  logic              inBranch,
   input  logic              inRegWrite,
   input  logic              inMemToReg,
   output logic              memReq,
   output logic              memWe,
   output logic [AW-1:0]     memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic [DATA_W-1:0] memRData,
   input  logic              memAck,
   output logic              stall,
   output logic              pcSrc,
   output logic [DATA_W-1:0] branchTarget,
   output logic              outValid,
   output logic              outRegWrite,
   output logic              outMemToReg,
   output logic [DATA_W-1:0] outReadData,
   output logic [DATA_W-1:0] outOutAlu,
   output logic [REG_W-1:0]  outMux5b,
   output logic              memErr
);
   state_e            state_q, state_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
   logic              is_rd_q, is_rd_d, rw_c_q, rw_c_d, mtr_c_q, mtr_c_d;
   logic [REG_W-1:0]  rd_c_q, rd_c_d;
   logic              out_valid_q, out_valid_d, out_rw_q, out_rw_d, out_mtr_q, out_mtr_d;
   logic [DATA_W-1:0] out_rdata_q, out_rdata_d, out_alu_q, out_alu_d;
   logic [REG_W-1:0]  out_rd_q, out_rd_d;
   logic              mem_err_q, mem_err_d;
   logic              in_wait, mem_op, aligned, done, expired;
   assign in_wait = (state_q == WAIT);
   assign mem_op  = inValid && (inMemRead || inMemWrite);
   assign aligned = (inOutAlu[1:0] == 2'b00);
   assign done    = in_wait && (memAck || expired);
   mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .start   (in_wait),
      .clear   (done),
      .expired (expired)
   );
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      is_rd_d     = is_rd_q;
      rw_c_d      = rw_c_q;
      mtr_c_d     = mtr_c_q;
      rd_c_d      = rd_c_q;
      out_valid_d = 1'b0;
      out_rw_d    = out_rw_q;
      out_mtr_d   = out_mtr_q;
      out_rdata_d = out_rdata_q;
      out_alu_d   = out_alu_q;
      out_rd_d    = out_rd_q;
      mem_err_d   = mem_err_q;
      if (!in_wait && inValid && (!mem_op || !aligned)) begin
         out_valid_d = 1'b1;
         out_rw_d    = mem_op ? 1'b0 : inRegWrite;
         out_mtr_d   = inMemToReg;
         out_rdata_d = '0;
         out_alu_d   = inOutAlu;
         out_rd_d    = inMux5b;
         mem_err_d   = mem_err_q | mem_op;
      end else if (!in_wait && mem_op) begin
         state_d   = WAIT;
         mem_req_d = 1'b1;
         mem_we_d  = inMemWrite;
         addr_d    = inOutAlu;
         wdata_d   = inRD2;
         is_rd_d   = inMemRead && !inMemWrite;
         rw_c_d    = inRegWrite;
         mtr_c_d   = inMemToReg;
         rd_c_d    = inMux5b;
      end else if (done) begin
         // an ack in the expiring cycle still wins over the timeout
         state_d     = IDLE;
         mem_req_d   = 1'b0;
         mem_we_d    = 1'b0;
         out_valid_d = 1'b1;
         out_rw_d    = memAck ? rw_c_q : 1'b0;
         out_mtr_d   = mtr_c_q;
         out_rdata_d = (memAck && is_rd_q) ? memRData : '0;
         out_alu_d   = addr_q;
         out_rd_d    = rd_c_q;
         mem_err_d   = mem_err_q | !memAck;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         is_rd_q     <= 1'b0;
         rw_c_q      <= 1'b0;
         mtr_c_q     <= 1'b0;
         rd_c_q      <= '0;
         out_valid_q <= 1'b0;
         out_rw_q    <= 1'b0;
         out_mtr_q   <= 1'b0;
         out_rdata_q <= '0;
         out_alu_q   <= '0;
         out_rd_q    <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         is_rd_q     <= is_rd_d;
         rw_c_q      <= rw_c_d;
         mtr_c_q     <= mtr_c_d;
         rd_c_q      <= rd_c_d;
         out_valid_q <= out_valid_d;
         out_rw_q    <= out_rw_d;
         out_mtr_q   <= out_mtr_d;
         out_rdata_q <= out_rdata_d;
         out_alu_q   <= out_alu_d;
         out_rd_q    <= out_rd_d;
         mem_err_q   <= mem_err_d;
      end
   end
   // combinational outputs are gated so reset forces them low immediately
   assign stall        = !rst && (in_wait || (mem_op && aligned));
   assign pcSrc        = !rst && !in_wait && inValid && inBranch && inZf;
   assign branchTarget = inAdder;
   assign memReq       = mem_req_q;
   assign memWe        = mem_we_q;
   assign memAddr      = AW'(addr_q);
   assign memWData     = wdata_q;
   assign outValid     = out_valid_q;
   assign outRegWrite  = out_rw_q;
   assign outMemToReg  = out_mtr_q;
   assign outReadData  = out_rdata_q;
   assign outOutAlu    = out_alu_q;
   assign outMux5b     = out_rd_q;
   assign memErr       = mem_err_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed stimulus with a queue scoreboard checked by an
// independent monitor on every outValid pulse.
module tb_mem_stage_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] inAdder, inOutAlu, inRD2, memRData;
   logic [4:0]  inMux5b;
   logic        inZf, inValid, inMemRead, inMemWrite, inBranch, inRegWrite, inMemToReg, memAck;
   logic        memReq, memWe, stall, pcSrc, outValid, outRegWrite, outMemToReg, memErr;
   logic [31:0] memAddr, memWData, branchTarget, outReadData, outOutAlu;
   logic [4:0]  outMux5b;
   typedef struct {
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  mux;
      logic        rw;
      logic        mtr;
      logic        err;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   int total = 0;
   int bad = 0;
   mem_stage_ctrl dut (
      .clk(clk), .rst(rst), .inAdder(inAdder), .inZf(inZf), .inOutAlu(inOutAlu),
      .inRD2(inRD2), .inMux5b(inMux5b), .inValid(inValid), .inMemRead(inMemRead),
      .inMemWrite(inMemWrite), .inBranch(inBranch), .inRegWrite(inRegWrite),
      .inMemToReg(inMemToReg), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
      .memWData(memWData), .memRData(memRData), .memAck(memAck), .stall(stall),
      .pcSrc(pcSrc), .branchTarget(branchTarget), .outValid(outValid),
      .outRegWrite(outRegWrite), .outMemToReg(outMemToReg), .outReadData(outReadData),
      .outOutAlu(outOutAlu), .outMux5b(outMux5b), .memErr(memErr)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      inAdder = '0; inOutAlu = '0; inRD2 = '0; inMux5b = '0; inZf = 0; inValid = 0;
      inMemRead = 0; inMemWrite = 0; inBranch = 0; inRegWrite = 0; inMemToReg = 0;
   endtask
   task automatic check_zero(input string n);
      chk({n, "_memReq"}, memReq, 0);
      chk({n, "_memWe"}, memWe, 0);
      chk({n, "_memAddr"}, memAddr, 0);
      chk({n, "_memWData"}, memWData, 0);
      chk({n, "_stall"}, stall, 0);
      chk({n, "_pcSrc"}, pcSrc, 0);
      chk({n, "_outValid"}, outValid, 0);
      chk({n, "_outRegWrite"}, outRegWrite, 0);
      chk({n, "_outMemToReg"}, outMemToReg, 0);
      chk({n, "_outReadData"}, outReadData, 0);
      chk({n, "_outOutAlu"}, outOutAlu, 0);
      chk({n, "_outMux5b"}, outMux5b, 0);
      chk({n, "_memErr"}, memErr, 0);
   endtask
   task automatic issue_load(input logic [31:0] a, input logic [4:0] r);
      inValid = 1; inMemRead = 1; inOutAlu = a; inMux5b = r; inRegWrite = 1; inMemToReg = 1;
   endtask
   always @(negedge clk) begin
      if (outValid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_outValid: got 1 expected 0 at %0t", $time);
         end else begin
            e = sb.pop_front();
            chk("outReadData", outReadData, e.rd);
            chk("outOutAlu", outOutAlu, e.alu);
            chk("outMux5b", outMux5b, e.mux);
            chk("outRegWrite", outRegWrite, e.rw);
            chk("outMemToReg", outMemToReg, e.mtr);
            chk("memErr_at_out", memErr, e.err);
         end
      end
   end
   initial begin
      idle_inputs();
      memAck = 0; memRData = '0;
      #1 rst = 1;
      inValid = 1; inMemRead = 1; inBranch = 1; inZf = 1; inAdder = 32'h40;
      #2 check_zero("reset");
      idle_inputs();
      tick(); tick();
      rst = 0;
      // plain ALU result
      inValid = 1; inOutAlu = 32'h10; inMux5b = 3; inRegWrite = 1;
      #1 chk("alu_stall", stall, 0);
      sb.push_back('{32'h0, 32'h10, 5'd3, 1'b1, 1'b0, 1'b0});
      tick(); idle_inputs();
      chk("alu_stall_after", stall, 0);
      chk("alu_memReq", memReq, 0);
      // load with ack in the third WAIT cycle
      issue_load(32'h100, 5);
      #1 chk("ld_accept_stall", stall, 1);
      chk("ld_accept_memReq", memReq, 0);
      sb.push_back('{32'hDEADBEEF, 32'h100, 5'd5, 1'b1, 1'b1, 1'b0});
      tick(); idle_inputs();
      for (int i = 1; i <= 3; i++) begin
         chk("ld_memReq", memReq, 1);
         chk("ld_stall", stall, 1);
         chk("ld_memAddr", memAddr, 32'h100);
         chk("ld_memWe", memWe, 0);
         if (i == 3) begin memAck = 1; memRData = 32'hDEADBEEF; end
         tick();
      end
      memAck = 0; memRData = '0;
      chk("ld_done_memReq", memReq, 0);
      chk("ld_done_stall", stall, 0);
      // store; upstream inputs change and a branch shows up while waiting
      inValid = 1; inMemWrite = 1; inOutAlu = 32'h104; inRD2 = 32'h1234;
      #1 chk("st_accept_stall", stall, 1);
      sb.push_back('{32'h0, 32'h104, 5'd0, 1'b0, 1'b0, 1'b0});
      tick();
      idle_inputs();
      inValid = 1; inBranch = 1; inZf = 1; inAdder = 32'h40; inOutAlu = 32'h200; inRD2 = 32'hFFFF;
      #1 chk("wait_pcSrc", pcSrc, 0);
      chk("wait_branchTarget", branchTarget, 32'h40);
      chk("st_memWe", memWe, 1);
      chk("st_memWData", memWData, 32'h1234);
      chk("st_memAddr", memAddr, 32'h104);
      tick();
      idle_inputs();
      memAck = 1; memRData = 32'hAAAA;
      #1 chk("st_memWData_hold", memWData, 32'h1234);
      chk("st_memAddr_hold", memAddr, 32'h104);
      chk("st_memReq_hold", memReq, 1);
      tick();
      memAck = 0; memRData = '0;
      chk("st_done_memReq", memReq, 0);
      chk("st_done_memWe", memWe, 0);
      // branch in IDLE
      inValid = 1; inBranch = 1; inZf = 0; inAdder = 32'h40; inOutAlu = 32'h8;
      #1 chk("br_nz_pcSrc", pcSrc, 0);
      inZf = 1;
      #1 chk("br_pcSrc", pcSrc, 1);
      chk("br_target", branchTarget, 32'h40);
      chk("br_stall", stall, 0);
      sb.push_back('{32'h0, 32'h8, 5'd0, 1'b0, 1'b0, 1'b0});
      tick(); idle_inputs();
      // stray ack in IDLE
      memAck = 1; memRData = 32'h1;
      tick();
      memAck = 0; memRData = '0;
      chk("idle_ack_memReq", memReq, 0);
      // ack exactly in the expiring cycle
      issue_load(32'h200, 7);
      sb.push_back('{32'h55AA, 32'h200, 5'd7, 1'b1, 1'b1, 1'b0});
      tick(); idle_inputs();
      for (int i = 1; i <= 16; i++) begin
         chk("late_memReq", memReq, 1);
         if (i == 16) begin memAck = 1; memRData = 32'h55AA; end
         tick();
      end
      memAck = 0; memRData = '0;
      chk("late_done_memReq", memReq, 0);
      chk("late_memErr", memErr, 0);
      // timeout
      issue_load(32'h300, 9);
      sb.push_back('{32'h0, 32'h300, 5'd9, 1'b0, 1'b1, 1'b1});
      tick(); idle_inputs();
      for (int i = 1; i <= 16; i++) begin
         chk("to_memReq", memReq, 1);
         tick();
      end
      chk("to_done_memReq", memReq, 0);
      chk("to_memErr", memErr, 1);
      chk("to_stall", stall, 0);
      // reset in the middle of a WAIT
      issue_load(32'h400, 2);
      tick(); idle_inputs();
      tick();
      chk("rw_memReq_before", memReq, 1);
      rst = 1;
      #1 check_zero("rst_wait");
      tick(); tick();
      rst = 0;
      chk("rw_memReq_after", memReq, 0);
      tick();
      chk("rw_memReq_idle", memReq, 0);
      chk("rw_stall_idle", stall, 0);
      // misaligned load
      issue_load(32'h102, 4);
      #1 chk("mis_stall", stall, 0);
      sb.push_back('{32'h0, 32'h102, 5'd4, 1'b0, 1'b1, 1'b1});
      tick(); idle_inputs();
      chk("mis_memReq", memReq, 0);
      chk("mis_memErr", memErr, 1);
      tick();
      chk("mis_memReq2", memReq, 0);
      chk("mis_memErr_sticky", memErr, 1);
      tick(); tick(); tick();
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles before the memory request is abandoned.
REQ-002 SHALL have parameter AW, default 32, meaning the data-memory address width.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports inAdder  in  32  branch target; inZf  in  1  ALU zero flag; inOutAlu  in  32  ALU result / memory address; inRD2  in  32  store data; inMux5b  in  5  destination register (all from the EX/MEM buffer).
REQ-006 SHALL have ports inValid, inMemRead, inMemWrite, inBranch, inRegWrite, inMemToReg  in  1 each  EX/MEM control bits.
REQ-007 SHALL have ports memReq, memWe  out  1 each; memAddr  out  AW; memWData  out  32; memRData  in  32; memAck  in  1  data-memory request/acknowledge channel.
REQ-008 SHALL have ports stall  out  1  freeze upstream pipeline; pcSrc  out  1  take branch; branchTarget  out  32.
REQ-009 SHALL have ports outValid, outRegWrite, outMemToReg  out  1 each; outReadData, outOutAlu  out  32 each; outMux5b  out  5; memErr  out  1  (MEM/WB side).

Function
REQ-010 SHALL implement FSM states IDLE and WAIT.
REQ-011 In IDLE, inValid with neither inMemRead nor inMemWrite SHALL register outOutAlu, outMux5b, outRegWrite, outMemToReg and outValid=1 at the next edge (latency 1); outReadData=0.
REQ-012 In IDLE, inValid with inMemRead or inMemWrite and inOutAlu[1:0]==0 SHALL capture address, store data and control, then drive memReq=1, memWe=inMemWrite and go to WAIT at the next edge.
REQ-013 In IDLE, inValid with a memory op and inOutAlu[1:0]!=0 SHALL issue no request, set memErr, and emit outValid=1 with outRegWrite=0.
REQ-014 In WAIT, memReq, memWe, memAddr and memWData SHALL hold stable until memAck=1 or the timeout.
REQ-015 stall SHALL be 1 combinationally while in WAIT and in the IDLE cycle that accepts a memory op; otherwise 0.
REQ-016 memAck=1 in WAIT SHALL register memRData into outReadData (reads only; 0 for writes), set outValid=1 for one cycle, drop memReq and return to IDLE.
REQ-017 memAck while in IDLE SHALL be ignored.
REQ-018 After TIMEOUT WAIT cycles without memAck, the block SHALL drop memReq, set memErr, emit outValid=1 with outRegWrite=0, and return to IDLE.
REQ-019 memAck arriving in the same cycle the timeout expires SHALL count as success; memErr stays unchanged.
REQ-020 outValid SHALL be 0 in every cycle not covered by REQ-011, 013, 016 or 018.
REQ-021 pcSrc SHALL equal inValid & inBranch & inZf, combinational, and SHALL be forced to 0 while in WAIT; branchTarget SHALL equal inAdder.
REQ-022 memErr SHALL be sticky and clear only on reset.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, zero the timeout counter, and drive every output to 0: memReq, memWe, memAddr, memWData, stall, pcSrc, outValid, outRegWrite, outMemToReg, outReadData, outOutAlu, outMux5b, memErr.
REQ-024 Reset asserted during WAIT SHALL abandon the request, with memReq=0 before the next edge and no outValid pulse.

Structure
REQ-025 A shared package mem_pkg SHALL hold the state encoding (IDLE, WAIT), the TIMEOUT default and the REG_W=5 and DATA_W=32 constants.
REQ-026 The timeout counter SHALL be a sub-module mem_wdog with ports clk, rst, start, clear and expired.

Verification
REQ-027 ALU op inValid=1, inOutAlu=0x0000_0010, inMux5b=3, inRegWrite=1 -> next cycle outValid=1, outOutAlu=0x10, outMux5b=3, stall=0 throughout.
REQ-028 Load at address 0x100, memAck after 3 WAIT cycles with memRData=0xDEAD_BEEF -> memReq high for 3 cycles, stall high 4 cycles, outReadData=0xDEADBEEF, one-cycle outValid.
REQ-029 Store at address 0x104 with inRD2=0x1234 -> memWe=1, memWData=0x1234, memAddr=0x104 held stable until memAck; outReadData=0.
REQ-030 Load at address 0x102 -> memReq never asserted, memErr=1, outValid=1 with outRegWrite=0.
REQ-031 Load with memAck never asserted (TIMEOUT=16) -> memReq drops after 16 WAIT cycles, memErr=1; memAck on cycle 16 instead -> success, memErr=0.
REQ-032 Branch inBranch=1, inZf=1, inAdder=0x40 in IDLE -> pcSrc=1, branchTarget=0x40 the same cycle; same inputs during WAIT -> pcSrc=0; rst pulsed mid-WAIT -> all outputs 0, no outValid pulse.
